pipe_trace_buffer: RTL and testbench

- Synthesizable, parametrised trace-capture block for the pipelined CPU; a hardware successor to bench-side signal monitoring.
- Samples CHANNELS probe buses of WIDTH bits (e.g. ALU result, R15 writeback, operand data) into a circular buffer of DEPTH entries.
- Keeps pre-trigger history, captures POST_TRIG samples after a trigger, then freezes for ordered oldest-first readout over a valid handshake.

---
 rtl/pipe_trace_buffer.sv | 163 ++++++++++++++++
 tb/tb_pipe_trace_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_trace_buffer
// Description : Circular trace buffer for CPU probe buses with pre-trigger
//               history, post-trigger capture and oldest-first readout.
//               Optional TRACE_TIMESTAMP_EN stores a 16-bit cycle stamp.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_trace_buffer #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 32,
    parameter int POST_TRIG = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm,
    input  logic                      trig,
    input  logic                      cap_valid,
    input  logic [CHANNELS*WIDTH-1:0] cap_data,
    input  logic                      rd_en,
    output logic [CHANNELS*WIDTH-1:0] rd_data,
    output logic                      rd_valid,
    output logic [1:0]                state,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      wrapped
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [15:0]               rd_ts
`endif
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam int c_data_w = CHANNELS * WIDTH;
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_post_trig = c_cnt_w'(POST_TRIG);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_data_w-1:0]   r_mem [DEPTH];
    logic [c_addr_w-1:0]   r_wr_ptr;
    logic [c_addr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_cnt_w-1:0]    r_post_cnt;
    logic                  r_wrapped;
    logic                  r_rd_valid;
    logic [c_data_w-1:0]   r_rd_data;

    logic                  w_wr;
    logic                  w_rd;
    logic                  w_full;
    logic                  w_post_inc;
    logic                  w_post_done;
    logic                  w_enter_done;
    logic [c_addr_w-1:0]   w_wr_ptr_nxt;
    logic [c_cnt_w-1:0]    w_count_nxt;

    // arm overrides everything in the same cycle, so it masks writes and reads
    assign w_wr   = cap_valid && !arm && (r_state == ST_ARMED || r_state == ST_POST);
    assign w_rd   = rd_en && !arm && (r_state == ST_DONE) && (r_count != '0);
    assign w_full = (r_count == c_depth);

    assign w_post_inc  = w_wr && (r_state == ST_POST || (r_state == ST_ARMED && trig));
    assign w_post_done = w_post_inc && ((r_post_cnt + 1'b1) == c_post_trig);

    assign w_wr_ptr_nxt = w_wr ? r_wr_ptr + 1'b1 : r_wr_ptr;
    assign w_count_nxt  = (w_wr && !w_full) ? r_count + 1'b1 : r_count;
    assign w_enter_done = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

    always_comb begin
        w_state_nxt = r_state;
        if (arm) begin
            w_state_nxt = ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED: if (trig) w_state_nxt = w_post_done ? ST_DONE : ST_POST;
                ST_POST:  if (w_post_done) w_state_nxt = ST_DONE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= cap_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_wrapped  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else if (arm) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_wrapped  <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd;
            if (w_wr) begin
                r_wr_ptr <= w_wr_ptr_nxt;
                r_count  <= w_count_nxt;
                if (w_full) r_wrapped <= 1'b1;
            end
            if (w_post_inc) r_post_cnt <= r_post_cnt + 1'b1;
            // low address bits of a full count are zero, so a full buffer starts at wr_ptr
            if (w_enter_done) r_rd_ptr <= w_wr_ptr_nxt - w_count_nxt[c_addr_w-1:0];
            if (w_rd) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_count   <= r_count - 1'b1;
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] r_ts_cnt;
    logic [15:0] r_ts_mem [DEPTH];
    logic [15:0] r_rd_ts;

    always_ff @(posedge clk) begin
        if (rst) r_ts_cnt <= '0;
        else     r_ts_cnt <= r_ts_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_ts_mem[r_wr_ptr] <= r_ts_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst)       r_rd_ts <= '0;
        else if (w_rd) r_rd_ts <= r_ts_mem[r_rd_ptr];
    end

    assign rd_ts = r_rd_ts;
`endif

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign state    = r_state;
    assign count    = r_count;
    assign wrapped  = r_wrapped;

endmodule
`default_nettype wire

// File: tb/tb_pipe_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_trace_buffer
// Description : Directed vector bench for pipe_trace_buffer (DEPTH=8,
//               POST_TRIG=3, CHANNELS=2, WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_trace_buffer;

    localparam int WIDTH     = 16;
    localparam int CHANNELS  = 2;
    localparam int DEPTH     = 8;
    localparam int POST_TRIG = 3;

    logic        clk;
    logic        rst;
    logic        arm;
    logic        trig;
    logic        cap_valid;
    logic [31:0] cap_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [1:0]  state;
    logic [3:0]  count;
    logic        wrapped;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] rd_ts;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pipe_trace_buffer #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH),
        .POST_TRIG(POST_TRIG)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .trig     (trig),
        .cap_valid(cap_valid),
        .cap_data (cap_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .state    (state),
        .count    (count),
        .wrapped  (wrapped)
`ifdef TRACE_TIMESTAMP_EN
        ,
        .rd_ts    (rd_ts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        arm;
        logic        trig;
        logic        cv;
        logic        rd;
        logic [15:0] d;
        logic [1:0]  es;
        logic [3:0]  ec;
        logic        ew;
        logic        ev;
        logic [15:0] ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic a, logic t, logic c, logic rd,
                                logic [15:0] d, logic [1:0] es, logic [3:0] ec,
                                logic ew, logic ev, logic [15:0] ed);
        vec_t v;
        v.rst = r; v.arm = a; v.trig = t; v.cv = c; v.rd = rd; v.d = d;
        v.es = es; v.ec = ec; v.ew = ew; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst       = v.rst;
        arm       = v.arm;
        trig      = v.trig;
        cap_valid = v.cv;
        rd_en     = v.rd;
        cap_data  = {v.d, v.d};
        @(posedge clk);
        #1;
        chk("state", idx, 32'(state), 32'(v.es));
        chk("count", idx, 32'(count), 32'(v.ec));
        chk("wrapped", idx, 32'(wrapped), 32'(v.ew));
        chk("rd_valid", idx, 32'(rd_valid), 32'(v.ev));
        if (v.ev)  chk("rd_data", idx, rd_data, {v.ed, v.ed});
        if (v.rst) chk("rd_data_rst", idx, rd_data, 32'h0);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; trig = 1'b0; cap_valid = 1'b0; rd_en = 1'b0;
        cap_data = '0;

        // reset, then IDLE ignores trig/cap_valid/rd_en
        tbl.push_back(mk(1,0,0,0,0,16'h0, 0,0,0,0,16'h0));
        tbl.push_back(mk(1,0,0,0,0,16'h0, 0,0,0,0,16'h0));
        tbl.push_back(mk(0,0,1,1,1,16'h55,0,0,0,0,16'h0));
        tbl.push_back(mk(0,0,1,1,1,16'h56,0,0,0,0,16'h0));
        // basic capture: 4 pre, trigger sample, 2 post; then readout
        tbl.push_back(mk(0,1,0,0,0,16'h0, 1,0,0,0,16'h0));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(0,0,0,1,0,16'(i), 1,4'(i),0,0,16'h0));
        tbl.push_back(mk(0,0,1,1,0,16'h5, 2,5,0,0,16'h0));
        tbl.push_back(mk(0,0,0,1,0,16'h6, 2,6,0,0,16'h0));
        tbl.push_back(mk(0,0,0,1,0,16'h7, 3,7,0,0,16'h0));
        tbl.push_back(mk(0,0,0,1,0,16'h99,3,7,0,0,16'h0));
        for (int i = 1; i <= 7; i++)
            tbl.push_back(mk(0,0,0,0,1,16'h0, 3,4'(7-i),0,1,16'(i)));
        tbl.push_back(mk(0,0,0,0,1,16'h0, 3,0,0,0,16'h0));
        // trigger without sample, sparse post samples
        tbl.push_back(mk(0,1,0,0,0,16'h0, 1,0,0,0,16'h0));
        tbl.push_back(mk(0,0,1,0,0,16'h0, 2,0,0,0,16'h0));
        tbl.push_back(mk(0,0,0,0,0,16'h0, 2,0,0,0,16'h0));
        tbl.push_back(mk(0,0,0,1,0,16'hA, 2,1,0,0,16'h0));
        tbl.push_back(mk(0,0,0,0,0,16'h0, 2,1,0,0,16'h0));
        tbl.push_back(mk(0,0,0,1,0,16'hB, 2,2,0,0,16'h0));
        tbl.push_back(mk(0,0,0,0,0,16'h0, 2,2,0,0,16'h0));
        tbl.push_back(mk(0,0,0,1,0,16'hC, 3,3,0,0,16'h0));
        tbl.push_back(mk(0,0,0,0,1,16'h0, 3,2,0,1,16'hA));
        tbl.push_back(mk(0,0,0,0,1,16'h0, 3,1,0,1,16'hB));
        tbl.push_back(mk(0,0,0,0,1,16'h0, 3,0,0,1,16'hC));
        // arm+trig: trig and sample dropped; then arm+rd aborts the read
        tbl.push_back(mk(0,1,1,1,0,16'h77,1,0,0,0,16'h0));
        tbl.push_back(mk(0,0,0,1,0,16'h31,1,1,0,0,16'h0));
        tbl.push_back(mk(0,0,1,1,0,16'h32,2,2,0,0,16'h0));
        tbl.push_back(mk(0,0,0,1,0,16'h33,2,3,0,0,16'h0));
        tbl.push_back(mk(0,0,0,1,0,16'h34,3,4,0,0,16'h0));
        tbl.push_back(mk(0,0,0,0,1,16'h0, 3,3,0,1,16'h31));
        tbl.push_back(mk(0,1,0,0,1,16'h0, 1,0,0,0,16'h0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // wrap-around: 12 pre samples into 8 entries
        apply(mk(0,1,0,0,0,16'h0,1,0,0,0,16'h0), 100);
        for (int i = 1; i <= 12; i++)
            apply(mk(0,0,0,1,0,16'(i),1,(i > 8) ? 4'd8 : 4'(i),(i > 8),0,16'h0), 100 + i);
        apply(mk(0,0,1,1,0,16'd13,2,8,1,0,16'h0), 113);
        apply(mk(0,0,0,1,0,16'd14,2,8,1,0,16'h0), 114);
        apply(mk(0,0,0,1,0,16'd15,3,8,1,0,16'h0), 115);
        for (int i = 0; i < 8; i++)
            apply(mk(0,0,0,0,1,16'h0,3,4'(7-i),1,1,16'(8+i)), 120 + i);

        // reset mid-POST, then a fresh capture
        apply(mk(0,1,0,0,0,16'h0,1,0,0,0,16'h0), 200);
        for (int i = 1; i <= 4; i++)
            apply(mk(0,0,0,1,0,16'(i),1,4'(i),0,0,16'h0), 200 + i);
        apply(mk(0,0,1,1,0,16'h5,2,5,0,0,16'h0), 205);
        apply(mk(1,0,0,1,0,16'h6,0,0,0,0,16'h0), 206);
        apply(mk(0,1,0,0,0,16'h0,1,0,0,0,16'h0), 207);
        apply(mk(0,0,1,1,0,16'h21,2,1,0,0,16'h0), 208);
        apply(mk(0,0,0,1,0,16'h22,2,2,0,0,16'h0), 209);
        apply(mk(0,0,0,1,0,16'h23,3,3,0,0,16'h0), 210);
        apply(mk(0,0,0,0,1,16'h0,3,2,0,1,16'h21), 211);

`ifdef TRACE_TIMESTAMP_EN
        begin
            logic [15:0] prev_ts;
            int          gap [4];
            gap = '{1, 1, 2, 1};
            apply(mk(0,1,0,0,0,16'h0,1,0,0,0,16'h0), 300);
            apply(mk(0,0,0,1,0,16'h41,1,1,0,0,16'h0), 301);
            apply(mk(0,0,0,1,0,16'h42,1,2,0,0,16'h0), 302);
            apply(mk(0,0,1,1,0,16'h43,2,3,0,0,16'h0), 303);
            apply(mk(0,0,0,0,0,16'h0,2,3,0,0,16'h0), 304);
            apply(mk(0,0,0,1,0,16'h44,2,4,0,0,16'h0), 305);
            apply(mk(0,0,0,1,0,16'h45,3,5,0,0,16'h0), 306);
            for (int i = 0; i < 5; i++) begin
                apply(mk(0,0,0,0,1,16'h0,3,4'(4-i),0,1,16'(16'h41+i)), 310 + i);
                if (i > 0) chk("rd_ts_gap", 310 + i, 32'(rd_ts - prev_ts), 32'(gap[i-1]));
                prev_ts = rd_ts;
            end
        end
`endif

        rst = 1'b0; arm = 1'b0; trig = 1'b0; cap_valid = 1'b0; rd_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
